bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
It sits directly upstream of the 4-bit binary-to-excess-3 converter. Each 4-bit BCD digit it produces is applied to one excess-3 converter instance to form multi-digit excess-3 codes.
Start/done handshake; the result is held until the next conversion completes.

Parameters:
BIN_W, 8, width of the binary input (>=4).
DIGITS, 3, number of BCD digits produced (>=1).

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a conversion; sampled only when idle.
bin_in  input  BIN_W  unsigned binary operand, sampled with an accepted start.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when bcd_out/overflow are updated.
bcd_out  output  4*DIGITS  result; digit k occupies bits [4k+3:4k], with digit 0 the least significant.
overflow  output  1  value exceeds 10^DIGITS-1; valid with done and held with bcd_out.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst); all state is clocked by clk and cleared by rst.
- Reset values: busy=0, done=0, bcd_out=0, overflow=0. Internal state goes to IDLE, shift register and counter to 0.
- Internal registers:
  - bin shift register, BIN_W bits.
  - BCD scratch, 4*DIGITS bits.
  - sticky ovf bit.
  - bit counter, $clog2(BIN_W+1) bits.
- States: IDLE, SHIFT.
- IDLE:
  - busy=0.
  - On the edge where start=1: latch bin_in, clear scratch and ovf, set counter=BIN_W, go to SHIFT.
  - start=0: remain in IDLE, outputs unchanged.
- SHIFT (busy=1), per edge:
  - Every scratch digit >=5 has 3 added (all digits corrected in parallel from pre-correction values).
  - The corrected scratch then shifts left 1, taking bin MSB into bit 0; bin shifts left 1.
  - The bit shifted out of the top of scratch is ORed into ovf.
  - Counter decrements.
- Completion: on the edge where counter goes 1->0:
  - bcd_out <= final scratch and overflow <= final ovf (including that edge's shift-out).
  - done <= 1; state -> IDLE.
- done is registered and high for exactly one cycle; it clears on the next edge.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+BIN_W.
- busy is high for exactly BIN_W cycles per conversion.
- start while busy is ignored: no restart, and bin_in is not resampled.
- start high during the done cycle (state is IDLE) is accepted, giving back-to-back conversions with no dead cycle.
- start held high continuously gives one conversion every BIN_W+1 cycles.
- bcd_out and overflow change only on completion edges or reset. Intermediate scratch values are never visible.
- When overflow=1, bcd_out holds the low DIGITS decimal digits of the value (value mod 10^DIGITS).
- Every bcd_out digit is always in the range 0..9.
- rst asserted mid-conversion:
  - Aborts immediately; all outputs return to reset values asynchronously.
  - No done pulse; the partial result is discarded.
  - First start after rst deassertion behaves as from power-up.

Test Plan:
- Defaults: rst pulse, then start with bin_in=0 -> done exactly 8 cycles after the accepting edge; bcd_out=12'h000, overflow=0, busy high for 8 cycles.
- bin_in=255 -> bcd_out=12'h255. Sweep 0..255 with each 4-bit digit checked against the decimal value, overflow always 0, and each digit fed to the excess-3 converter giving digit+3.
- bin_in=99 accepted; 3 cycles later start with bin_in=7 -> ignored, bcd_out=12'h099, exactly one done pulse.
- start held high through done with bin_in=128 then 64 -> done pulses 9 cycles apart; bcd_out=12'h128 then 12'h064.
- bin_in=200, rst asserted 4 cycles after start -> busy=0 and bcd_out=0 immediately, no done; then bin_in=37 -> 12'h037.
- Parameters DIGITS=2, bin_in=200 -> bcd_out=8'h00, overflow=1. Then bin_in=99 -> bcd_out=8'h99, overflow=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Start/done handshake; bcd_out/overflow hold the last completed result.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [SW-1:0]   scr_q, scr_d;
    logic [SW-1:0]   corr;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic            ovf_out_q, ovf_out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scr_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scr_q     <= scr_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;

        // All digits are corrected from their pre-correction values in parallel.
        corr = scr_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5)
                corr[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {corr[SW-2:0], bin_q[BIN_W-1]};
                ovf_d = ovf_q | corr[SW-1];
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d     = scr_d;
                    ovf_out_d = ovf_d;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_out_q;

endmodule
